jtframe_joy_serial_tx: RTL and testbench
========================================

Name: jtframe_joy_serial_tx

Overview:
- Serial joystick responder: the board-side end of the JOY_CLK / JOY_LOAD / JOY_DATA link that the frame samples on Neptuno/Multicore targets.
- Emulates a parallel-load shift register: latches a parallel button word while JOY_LOAD is low, then shifts it out MSB-first on JOY_CLK rising edges.
- Used in frame simulation benches, and in FPGA builds that drive a joystick link to another core.
- Oversamples the link in the clk_sys domain; it does not clock on JOY_CLK.

Parameters:
- NBITS, 24, payload bits per frame (two players x 12), must be >= 2.
- SYNC_STAGES, 2, synchroniser depth on JOY_CLK and JOY_LOAD, range 2..3.
- ACTIVE_LOW, 1, when 1 each JOY_DATA payload bit is the inverse of joy_par (pressed = 0 on the wire).
- IDLE_LEVEL, 1'b1, level shifted in and driven on JOY_DATA once the frame is exhausted.

Ports:
- clk_sys  in  1  system clock; must be >= 4x JOY_CLK frequency.
- rst  in  1  synchronous reset, active-high.
- joy_par  in  NBITS  parallel button word, active-high pressed; bit NBITS-1 is sent first.
- JOY_CLK  in  1  serial shift clock from the reader, asynchronous.
- JOY_LOAD  in  1  parallel load, active-low, asynchronous.
- JOY_DATA  out  1  serial data to the reader.
- busy  out  1  high while in state SHIFT.
- frame_done  out  1  one-cycle pulse when the last frame bit has been consumed.
- err_short  out  1  one-cycle pulse when a load aborts an incomplete frame.
- bit_cnt  out  6  rising clock edges counted in the current frame, saturating.

Behaviour:
- JOY_CLK and JOY_LOAD each pass through SYNC_STAGES flops, with reset value 1 for both.
- A rise is detected by comparing the last synchroniser stage with one extra flop.
- Frame length FLEN = NBITS (NBITS+1 with the parity option); shift register width is FLEN.
- Reset values: sreg all IDLE_LEVEL, JOY_DATA = IDLE_LEVEL, state IDLE, busy 0, frame_done 0, err_short 0, bit_cnt 0.
- States:
  - IDLE: waits for the synchronised load to be low.
  - LOAD: while load is low, sreg <= payload every cycle (joy_par, XOR-inverted if ACTIVE_LOW) and bit_cnt <= 0. Clock edges are ignored. On load high go to SHIFT.
  - SHIFT: on each synchronised JOY_CLK rise, sreg <= {sreg[FLEN-2:0], IDLE_LEVEL} and bit_cnt += 1. When bit_cnt reaches FLEN on that edge, go to DONE with frame_done = 1 for that cycle.
  - DONE: further clock rises are ignored; bit_cnt holds at FLEN. Load low goes to LOAD.
- JOY_DATA is registered as sreg[FLEN-1].
- Latency: JOY_DATA changes SYNC_STAGES+2 clk_sys cycles after the external JOY_CLK rise or JOY_LOAD fall.
- Load low in SHIFT with bit_cnt < FLEN: err_short pulses for one cycle and the FSM goes to LOAD. Load low in SHIFT with bit_cnt = 0 is not an error.
- Clock rise and load fall detected in the same cycle: the load wins, there is no shift, and the err_short rule above applies.
- joy_par changes during SHIFT/DONE have no effect on the frame in flight.
- rst mid-frame returns everything to reset values on the next edge. The next load starts a clean frame.
- bit_cnt saturates at 63.

Optional Feature:
- Macro: JTFRAME_JOY_TX_PARITY_EN.
- Defined: FLEN = NBITS+1, and one odd-parity bit is appended after the payload, computed on the on-wire bits (post-inversion) so the total count of 1s in the FLEN bits is odd. frame_done fires after FLEN rises.
- Undefined: FLEN = NBITS and there is no parity logic.

Test Plan:
- Reset then idle: hold rst 3 cycles -> JOY_DATA = 1, busy = 0, bit_cnt = 0, no pulses.
- Normal frame: joy_par = 24'h800001, ACTIVE_LOW = 1, load pulse, then 24 JOY_CLK rises at clk_sys/8 -> sampled bits are 0, then 22x 1, then 0. frame_done pulses once after the 24th rise, then JOY_DATA = 1.
- Over-clocking: 30 rises after load -> bits 25..30 read IDLE_LEVEL = 1, bit_cnt = 24, no second frame_done.
- Short frame: load again after 10 rises -> err_short = 1 for exactly one cycle, and the new frame starts with the current joy_par MSB.
- Mid-frame changes: flip joy_par after 5 rises -> remaining bits still match the word latched at load. rst asserted at rise 12 -> JOY_DATA = 1, state IDLE, bit_cnt = 0.
- Parity (macro defined): joy_par = 24'h000000, ACTIVE_LOW = 1 -> 24 ones on the wire, parity bit 1 (25 ones, odd), frame_done after the 25th rise.

Source files
------------

// File: rtl/jtframe_joy_serial_tx.sv
// Board-side joystick responder: parallel-load, MSB-first shifter on JOY_CLK/JOY_LOAD.
// Define JTFRAME_JOY_TX_PARITY_EN to append one odd-parity bit to each frame.
module jtframe_joy_serial_tx #(
   parameter int   NBITS       = 24,
   parameter int   SYNC_STAGES = 2,
   parameter int   ACTIVE_LOW  = 1,
   parameter logic IDLE_LEVEL  = 1'b1
)(
   input  logic             clk_sys,
   input  logic             rst,
   input  logic [NBITS-1:0] joy_par,
   input  logic             JOY_CLK,
   input  logic             JOY_LOAD,
   output logic             JOY_DATA,
   output logic             busy,
   output logic             frame_done,
   output logic             err_short,
   output logic [5:0]       bit_cnt
);

`ifdef JTFRAME_JOY_TX_PARITY_EN
   localparam int FLEN = NBITS + 1;
`else
   localparam int FLEN = NBITS;
`endif
   localparam logic [6:0] FLEN7 = 7'(FLEN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_load_sync;
   logic                   r_clk_prev;
   logic [FLEN-1:0]        r_sreg;
   logic                   r_data;
   logic                   r_busy;
   logic                   r_frame_done;
   logic                   r_err_short;
   logic [5:0]             r_bit_cnt;

   logic [NBITS-1:0]       w_wire;
   logic [FLEN-1:0]        w_payload;
   logic                   w_clk_rise;
   logic                   w_load_low;
   logic [6:0]             w_cnt_inc;

   assign w_wire = (ACTIVE_LOW != 0) ? ~joy_par : joy_par;

`ifdef JTFRAME_JOY_TX_PARITY_EN
   // parity covers the on-wire bits so the frame has an odd number of ones
   assign w_payload = {w_wire, ~^w_wire};
`else
   assign w_payload = w_wire;
`endif

   assign w_clk_rise = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
   assign w_load_low = ~r_load_sync[SYNC_STAGES-1];
   assign w_cnt_inc  = {1'b0, r_bit_cnt} + 7'd1;

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_clk_sync   <= '1;
         r_load_sync  <= '1;
         r_clk_prev   <= 1'b1;
         r_sreg       <= {FLEN{IDLE_LEVEL}};
         r_data       <= IDLE_LEVEL;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_err_short  <= 1'b0;
         r_bit_cnt    <= 6'd0;
      end else begin
         r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], JOY_CLK};
         r_load_sync  <= {r_load_sync[SYNC_STAGES-2:0], JOY_LOAD};
         r_clk_prev   <= r_clk_sync[SYNC_STAGES-1];
         r_data       <= r_sreg[FLEN-1];
         r_frame_done <= 1'b0;
         r_err_short  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_load_low) begin
                  r_state   <= S_LOAD;
                  r_sreg    <= w_payload;
                  r_bit_cnt <= 6'd0;
               end
            end
            S_LOAD: begin
               if (w_load_low) begin
                  r_sreg    <= w_payload;
                  r_bit_cnt <= 6'd0;
               end else begin
                  r_state <= S_SHIFT;
                  r_busy  <= 1'b1;
               end
            end
            S_SHIFT: begin
               // a load beats a simultaneous clock rise
               if (w_load_low) begin
                  r_err_short <= (r_bit_cnt != 6'd0);
                  r_state     <= S_LOAD;
                  r_busy      <= 1'b0;
                  r_sreg      <= w_payload;
                  r_bit_cnt   <= 6'd0;
               end else if (w_clk_rise) begin
                  r_sreg    <= {r_sreg[FLEN-2:0], IDLE_LEVEL};
                  r_bit_cnt <= (r_bit_cnt == 6'h3F) ? 6'h3F : w_cnt_inc[5:0];
                  if (w_cnt_inc == FLEN7) begin
                     r_state      <= S_DONE;
                     r_busy       <= 1'b0;
                     r_frame_done <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (w_load_low) begin
                  r_state   <= S_LOAD;
                  r_sreg    <= w_payload;
                  r_bit_cnt <= 6'd0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign JOY_DATA   = r_data;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign err_short  = r_err_short;
   assign bit_cnt    = r_bit_cnt;

endmodule

// File: tb/tb_jtframe_joy_serial_tx.sv
// Bench for jtframe_joy_serial_tx: acts as the serial reader, compares against a frame model.
// Honours JTFRAME_JOY_TX_PARITY_EN when it is defined for the build.
module tb_jtframe_joy_serial_tx;

   localparam int NB  = 24;
   localparam int SS  = 2;
   localparam int ACT = 1;
   localparam logic IDLE = 1'b1;
`ifdef JTFRAME_JOY_TX_PARITY_EN
   localparam int FLEN = NB + 1;
`else
   localparam int FLEN = NB;
`endif

   logic          clk;
   logic          rst;
   logic [NB-1:0] joy_par;
   logic          JOY_CLK;
   logic          JOY_LOAD;
   logic          JOY_DATA;
   logic          busy;
   logic          frame_done;
   logic          err_short;
   logic [5:0]    bit_cnt;

   int n_pass  = 0;
   int n_total = 0;
   int fd_cnt  = 0;
   int es_cnt  = 0;

   logic m_bits [FLEN];
   int   m_rises  = 0;
   bit   m_active = 0;

   jtframe_joy_serial_tx #(
      .NBITS(NB), .SYNC_STAGES(SS), .ACTIVE_LOW(ACT), .IDLE_LEVEL(IDLE)
   ) dut (
      .clk_sys(clk), .rst(rst), .joy_par(joy_par),
      .JOY_CLK(JOY_CLK), .JOY_LOAD(JOY_LOAD), .JOY_DATA(JOY_DATA),
      .busy(busy), .frame_done(frame_done), .err_short(err_short),
      .bit_cnt(bit_cnt)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (err_short === 1'b1) es_cnt++;
   end

   // expected level on the wire before rise r of the current frame
   function automatic logic exp_bit(input int r);
      if (!m_active || r >= FLEN) return IDLE;
      return m_bits[r];
   endfunction

   function automatic int exp_cnt();
      return (m_rises < FLEN) ? m_rises : FLEN;
   endfunction

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [NB-1:0] w, output int exp_err);
      int ones;
      exp_err = (m_active && m_rises > 0 && m_rises < FLEN) ? 1 : 0;
      joy_par  = w;
      JOY_LOAD = 0;
      wait_n(6);
      JOY_LOAD = 1;
      wait_n(6);
      ones = 0;
      for (int i = 0; i < NB; i++) begin
         m_bits[i] = (ACT != 0) ? ~w[NB-1-i] : w[NB-1-i];
         ones += int'(m_bits[i]);
      end
`ifdef JTFRAME_JOY_TX_PARITY_EN
      m_bits[NB] = (ones % 2 == 0) ? 1'b1 : 1'b0;
`endif
      m_rises  = 0;
      m_active = 1;
   endtask

   task automatic rise();
      JOY_CLK = 1;
      wait_n(4);
      JOY_CLK = 0;
      wait_n(4);
      m_rises++;
   endtask

   task automatic test_reset();
      int fd0, es0;
      rst = 1;
      wait_n(3);
      rst = 0;
      fd0 = fd_cnt;
      es0 = es_cnt;
      wait_n(4);
      n_total++;
      if (JOY_DATA !== IDLE) $display("FAIL reset_data got %b want %b", JOY_DATA, IDLE);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
      else n_pass++;
      n_total++;
      if (bit_cnt !== 6'd0) $display("FAIL reset_cnt got %0d want 0", bit_cnt);
      else n_pass++;
      n_total++;
      if (fd_cnt != fd0 || es_cnt != es0 || frame_done !== 1'b0 || err_short !== 1'b0)
         $display("FAIL reset_pulses got fd=%0d es=%0d want none", fd_cnt - fd0, es_cnt - es0);
      else n_pass++;
   endtask

   task automatic test_normal();
      int e, fd0;
      logic fixed [NB];
      do_load(24'h800001, e);
      fd0 = fd_cnt;
      for (int i = 0; i < NB; i++) fixed[i] = (i == 0 || i == NB - 1) ? 1'b0 : 1'b1;
      n_total++;
      if (busy !== 1'b1) $display("FAIL normal_busy got %b want 1", busy);
      else n_pass++;
      for (int r = 0; r <= FLEN; r++) begin
         n_total++;
         if (JOY_DATA !== exp_bit(r))
            $display("FAIL normal_bit%0d got %b want %b", r, JOY_DATA, exp_bit(r));
         else n_pass++;
         if (r < NB) begin
            n_total++;
            if (JOY_DATA !== fixed[r])
               $display("FAIL normal_lit%0d got %b want %b", r, JOY_DATA, fixed[r]);
            else n_pass++;
         end
         if (r == 0) begin
            JOY_CLK = 1;
            wait_n(SS + 1);
            n_total++;
            if (JOY_DATA !== exp_bit(0))
               $display("FAIL latency_early got %b want %b", JOY_DATA, exp_bit(0));
            else n_pass++;
            wait_n(1);
            n_total++;
            if (JOY_DATA !== exp_bit(1))
               $display("FAIL latency_edge got %b want %b", JOY_DATA, exp_bit(1));
            else n_pass++;
            JOY_CLK = 0;
            wait_n(4);
            m_rises++;
         end else if (r < FLEN) begin
            rise();
         end
      end
      n_total++;
      if (fd_cnt - fd0 != 1) $display("FAIL normal_done got %0d want 1", fd_cnt - fd0);
      else n_pass++;
      n_total++;
      if (bit_cnt !== 6'(FLEN)) $display("FAIL normal_cnt got %0d want %0d", bit_cnt, FLEN);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL normal_idle got %b want 0", busy);
      else n_pass++;
   endtask

   task automatic test_overclock();
      int e, es0, fd0;
      es0 = es_cnt;
      do_load(NB'($urandom), e);
      n_total++;
      if (es_cnt - es0 != e) $display("FAIL over_err got %0d want %0d", es_cnt - es0, e);
      else n_pass++;
      fd0 = fd_cnt;
      for (int r = 0; r <= 30; r++) begin
         n_total++;
         if (JOY_DATA !== exp_bit(r))
            $display("FAIL over_bit%0d got %b want %b", r, JOY_DATA, exp_bit(r));
         else n_pass++;
         if (r < 30) rise();
      end
      n_total++;
      if (bit_cnt !== 6'(exp_cnt())) $display("FAIL over_cnt got %0d want %0d", bit_cnt, exp_cnt());
      else n_pass++;
      n_total++;
      if (fd_cnt - fd0 != 1) $display("FAIL over_done got %0d want 1", fd_cnt - fd0);
      else n_pass++;
   endtask

   task automatic test_short();
      int e, es0;
      do_load(NB'($urandom), e);
      for (int r = 0; r < 10; r++) rise();
      es0 = es_cnt;
      do_load(NB'($urandom), e);
      n_total++;
      if (es_cnt - es0 != 1 || e != 1) $display("FAIL short_err got %0d want 1", es_cnt - es0);
      else n_pass++;
      n_total++;
      if (JOY_DATA !== exp_bit(0) || bit_cnt !== 6'd0)
         $display("FAIL short_restart got %b/%0d want %b/0", JOY_DATA, bit_cnt, exp_bit(0));
      else n_pass++;
      for (int r = 1; r < 6; r++) begin
         rise();
         n_total++;
         if (JOY_DATA !== exp_bit(r))
            $display("FAIL short_bit%0d got %b want %b", r, JOY_DATA, exp_bit(r));
         else n_pass++;
      end
   endtask

   task automatic test_collision();
      int e, es0;
      e = (m_active && m_rises > 0 && m_rises < FLEN) ? 1 : 0;
      es0 = es_cnt;
      joy_par  = NB'($urandom);
      JOY_CLK  = 1;
      JOY_LOAD = 0;
      wait_n(6);
      JOY_CLK  = 0;
      JOY_LOAD = 1;
      wait_n(6);
      for (int i = 0; i < NB; i++) m_bits[i] = (ACT != 0) ? ~joy_par[NB-1-i] : joy_par[NB-1-i];
`ifdef JTFRAME_JOY_TX_PARITY_EN
      m_bits[NB] = ($countones(~joy_par) % 2 == 0) ? 1'b1 : 1'b0;
`endif
      m_rises = 0;
      n_total++;
      if (es_cnt - es0 != e) $display("FAIL coll_err got %0d want %0d", es_cnt - es0, e);
      else n_pass++;
      n_total++;
      if (JOY_DATA !== exp_bit(0) || bit_cnt !== 6'd0)
         $display("FAIL coll_noshift got %b/%0d want %b/0", JOY_DATA, bit_cnt, exp_bit(0));
      else n_pass++;
   endtask

   task automatic test_midframe();
      int e;
      do_load(NB'($urandom), e);
      for (int r = 0; r < 12; r++) begin
         if (r == 5) joy_par = ~joy_par;
         n_total++;
         if (JOY_DATA !== exp_bit(r))
            $display("FAIL mid_bit%0d got %b want %b", r, JOY_DATA, exp_bit(r));
         else n_pass++;
         rise();
      end
      rst = 1;
      wait_n(1);
      rst = 0;
      m_active = 0;
      m_rises  = 0;
      wait_n(2);
      n_total++;
      if (JOY_DATA !== IDLE || busy !== 1'b0 || bit_cnt !== 6'd0)
         $display("FAIL mid_rst got %b/%b/%0d want %b/0/0", JOY_DATA, busy, bit_cnt, IDLE);
      else n_pass++;
   endtask

   task automatic test_random();
      int e, es0, fd0, nr, edone;
      for (int f = 0; f < 6; f++) begin
         es0 = es_cnt;
         do_load(NB'($urandom), e);
         n_total++;
         if (es_cnt - es0 != e) $display("FAIL rnd%0d_err got %0d want %0d", f, es_cnt - es0, e);
         else n_pass++;
         fd0 = fd_cnt;
         nr = $urandom_range(FLEN + 3, 1);
         for (int r = 0; r <= nr; r++) begin
            n_total++;
            if (JOY_DATA !== exp_bit(r))
               $display("FAIL rnd%0d_bit%0d got %b want %b", f, r, JOY_DATA, exp_bit(r));
            else n_pass++;
            if (r < nr) rise();
         end
         edone = (nr >= FLEN) ? 1 : 0;
         n_total++;
         if (bit_cnt !== 6'(exp_cnt()) || fd_cnt - fd0 != edone)
            $display("FAIL rnd%0d_cnt got %0d/%0d want %0d/%0d", f, bit_cnt, fd_cnt - fd0, exp_cnt(), edone);
         else n_pass++;
      end
   endtask

   initial begin
      rst      = 1;
      joy_par  = '0;
      JOY_CLK  = 0;
      JOY_LOAD = 1;
      test_reset();
      test_normal();
      test_overclock();
      test_short();
      test_collision();
      test_midframe();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
